// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the 160x120 VGA drawing blocks
// (screen-fill FSM, line_drawer and later drawing engines).
//   H_RES / V_RES          : visible screen size in pixels
//   XW_DEF / YW_DEF / CW_DEF : default coordinate and colour widths
//   colour_t               : 1 bit per RGB channel
//   line_state_t           : line_drawer FSM states
package vga_pkg;

    localparam int H_RES  = 160;
    localparam int V_RES  = 120;

    localparam int XW_DEF = 8;
    localparam int YW_DEF = 7;
    localparam int CW_DEF = 3;

    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } line_state_t;

endpackage

// File: rtl/line_drawer_if.sv
// line_drawer_if: request/pixel bundle between a line requester and
// line_drawer.
//   master : drives start, x0, x1, y0, y1, colour_in; sees the pixel stream
//   slave  : the drawer; drives x, y, colour, plot, busy, done
//
// Handshake: start is a level request, sampled only while the drawer is
// idle; the endpoints and colour are captured on the edge that accepts it.
// The pixel side has no ready: each cycle with plot=1 carries one pixel
// that the adapter writes on the edge ending that cycle.
interface line_drawer_if #(
    parameter int XW = vga_pkg::XW_DEF,
    parameter int YW = vga_pkg::YW_DEF,
    parameter int CW = vga_pkg::CW_DEF
);

    logic          start;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [CW-1:0] colour_in;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;
    logic          busy;
    logic          done;

    modport master (
        output start, x0, x1, y0, y1, colour_in,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, x1, y0, y1, colour_in,
        output x, y, colour, plot, busy, done
    );

endinterface

// File: rtl/line_drawer.sv
// line_drawer: Bresenham line rasteriser feeding the vga_adapter pixel port.
// A start request latches two endpoints and a colour; after one INIT cycle
// the drawer emits one pixel per clock (x/y/colour with plot=1) until the
// far endpoint has been written, then holds done until start drops.
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-low
//   bus     : line_drawer_if.slave (request inputs, pixel/status outputs)
//   state_o : current FSM state, for observation
//
// Build option: define LINE_DRAWER_CLIP_EN to suppress plot for pixels at
// x >= H_RES or y >= V_RES; the walk and its cycle count are unchanged.
module line_drawer
    import vga_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    line_drawer_if.slave bus,
    output line_state_t  state_o
);

    // Error term width: wide enough for 2*err over any in-range endpoints.
    localparam int EW = XW + 3;
    typedef logic signed [EW-1:0] err_t;

    line_state_t   state_q;
    logic [XW-1:0] x0_q, x1_q, x_q;
    logic [YW-1:0] y0_q, y1_q, y_q;
    logic [CW-1:0] colour_q;
    logic          plot_q, busy_q, done_q;
    logic          sx_neg_q, sy_neg_q;
    err_t          dx_q, dy_q, err_q;

    // INIT values, formed from the latched endpoints.
    err_t ax0, ax1, ay0, ay1, dx_init, dy_init;
    assign ax0 = signed'({{(EW-XW){1'b0}}, x0_q});
    assign ax1 = signed'({{(EW-XW){1'b0}}, x1_q});
    assign ay0 = signed'({{(EW-YW){1'b0}}, y0_q});
    assign ay1 = signed'({{(EW-YW){1'b0}}, y1_q});
    assign dx_init = (ax1 >= ax0) ? (ax1 - ax0) : (ax0 - ax1);
    assign dy_init = (ay1 >= ay0) ? (ay0 - ay1) : (ay1 - ay0);  // -|y1-y0|

    // One Bresenham step; both decisions use the pre-update err.
    err_t          e2, err_d;
    logic          step_x, step_y, at_end;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;

    assign e2     = err_q <<< 1;
    assign step_x = (e2 >= dy_q);
    assign step_y = (e2 <= dx_q);
    assign at_end = (x_q == x1_q) && (y_q == y1_q);

    always_comb begin
        err_d = err_q;
        if (step_x) err_d = err_d + dy_q;
        if (step_y) err_d = err_d + dx_q;
    end

    assign x_d = !step_x ? x_q : (sx_neg_q ? x_q - 1'b1 : x_q + 1'b1);
    assign y_d = !step_y ? y_q : (sy_neg_q ? y_q - 1'b1 : y_q + 1'b1);

    // plot value for the first pixel (init_vis) and for each stepped pixel.
    logic init_vis, step_vis;
`ifdef LINE_DRAWER_CLIP_EN
    assign init_vis = (int'(x0_q) < H_RES) && (int'(y0_q) < V_RES);
    assign step_vis = (int'(x_d)  < H_RES) && (int'(y_d)  < V_RES);
`else
    assign init_vis = 1'b1;
    assign step_vis = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x0_q     <= bus.x0;
                        x1_q     <= bus.x1;
                        y0_q     <= bus.y0;
                        y1_q     <= bus.y1;
                        colour_q <= bus.colour_in;
                        busy_q   <= 1'b1;
                        state_q  <= INIT;
                    end
                end
                INIT: begin
                    dx_q     <= dx_init;
                    dy_q     <= dy_init;
                    err_q    <= dx_init + dy_init;
                    sx_neg_q <= !(x0_q < x1_q);
                    sy_neg_q <= !(y0_q < y1_q);
                    x_q      <= x0_q;
                    y_q      <= y0_q;
                    plot_q   <= init_vis;
                    state_q  <= DRAW;
                end
                DRAW: begin
                    // The pixel on the outputs now is written at this edge;
                    // if it was the far endpoint the line is complete.
                    if (at_end) begin
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        err_q  <= err_d;
                        x_q    <= x_d;
                        y_q    <= y_d;
                        plot_q <= step_vis;
                    end
                end
                DONE: begin
                    // Wait for start to drop so a held key draws only once.
                    if (!bus.start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign state_o    = state_q;

endmodule
